// File: rtl/add_iter_pkg.sv
// Shared types for the iterative chunked adder/subtractor.
// Op codes, FSM states and op decode helpers.
package add_iter_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDU = 2'd2,
    OP_SUBU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_sub(op_e o);
    return (o == OP_SUB) || (o == OP_SUBU);
  endfunction

  function automatic logic op_is_signed(op_e o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// One CHUNK-bit slice adder with carry in/out.
// Also exposes operand MSBs for signed overflow detection.
module add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             a_msb_o,
  output logic             b_msb_o
);

  logic [CHUNK:0] full;

  assign full    = {1'b0, a_i} + {1'b0, b_i}
                 + {{CHUNK{1'b0}}, cin_i};
  assign sum_o   = full[CHUNK-1:0];
  assign cout_o  = full[CHUNK];
  assign a_msb_o = a_i[CHUNK-1];
  assign b_msb_o = b_i[CHUNK-1];

endmodule

// File: rtl/add_iter.sv
// Iterative adder/subtractor: one CHUNK-bit slice per cycle,
// valid/ready on both sides, flags registered with the result.
module add_iter
  import add_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] digit1,
  input  logic [WIDTH-1:0] digit2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N    = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("add_iter: CHUNK must be >= 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("add_iter: WIDTH must be a multiple of CHUNK");
  end

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  op_e               op_q;
  logic [WIDTH-1:0]  result_q;
  logic              carry_q;
  logic              overflow_q;
  logic              zero_q;
  logic              out_valid_q;

  logic [CHUNK-1:0]  sum;
  logic              cout;
  logic              a_msb;
  logic              b_msb;
  logic [WIDTH-1:0]  result_d;
  logic              last;

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (a_q[idx_q*CHUNK +: CHUNK]),
    .b_i     (b_q[idx_q*CHUNK +: CHUNK]),
    .cin_i   (carry_q),
    .sum_o   (sum),
    .cout_o  (cout),
    .a_msb_o (a_msb),
    .b_msb_o (b_msb)
  );

  assign last = (idx_q == IDXW'(N - 1));

  always_comb begin
    result_d = result_q;
    result_d[idx_q*CHUNK +: CHUNK] = sum;
  end

  // b_q holds ~digit2 for subtracts; carry_q seeds the +1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= digit1;
            b_q     <= op_is_sub(op) ? ~digit2 : digit2;
            op_q    <= op;
            carry_q <= op_is_sub(op);
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          result_q <= result_d;
          carry_q  <= cout;
          idx_q    <= idx_q + IDXW'(1);
          if (last) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            zero_q      <= (result_d == '0);
            overflow_q  <= op_is_signed(op_q)
                         & (a_msb == b_msb)
                         & (sum[CHUNK-1] != a_msb);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add_iter.sv
// Directed bench for add_iter: 32/8 instance plus a 16/16
// single-chunk instance.
module tb_add_iter;
  import add_iter_pkg::*;

  logic        clk;
  logic        rst;

  logic        a_in_valid;
  logic        a_in_ready;
  op_e         a_op;
  logic [31:0] a_d1;
  logic [31:0] a_d2;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [31:0] a_res;
  logic        a_carry;
  logic        a_ovf;
  logic        a_zero;

  logic        b_in_valid;
  logic        b_in_ready;
  op_e         b_op;
  logic [15:0] b_d1;
  logic [15:0] b_d2;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [15:0] b_res;
  logic        b_carry;
  logic        b_ovf;
  logic        b_zero;

  int checks;
  int errors;

  add_iter #(.WIDTH(32), .CHUNK(8)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .op        (a_op),
    .digit1    (a_d1),
    .digit2    (a_d2),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .result    (a_res),
    .carry     (a_carry),
    .overflow  (a_ovf),
    .zero      (a_zero)
  );

  add_iter #(.WIDTH(16), .CHUNK(16)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .op        (b_op),
    .digit1    (b_d1),
    .digit2    (b_d2),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .result    (b_res),
    .carry     (b_carry),
    .overflow  (b_ovf),
    .zero      (b_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request to dut_a and count cycles to out_valid.
  task automatic run_a(input op_e o, input logic [31:0] x,
                       input logic [31:0] y, output int lat);
    a_op       = o;
    a_d1       = x;
    a_d2       = y;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_d1       = 32'hDEAD_BEEF;
    a_d2       = 32'h1234_5678;
    a_op       = OP_SUBU;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_out_valid, a_res, a_carry, a_ovf, a_zero} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h c=%b o=%b z=%b want all 0",
               a_out_valid, a_res, a_carry, a_ovf, a_zero);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    run_a(OP_ADD, 32'd10, 32'd15, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency: got %0d want 4", lat);
    end
    checks++;
    if ({a_res, a_carry, a_ovf, a_zero} !== {32'd25, 3'b000}) begin
      errors++;
      $display("FAIL add_10_15: got res=%h c=%b o=%b z=%b want 19 0 0 0",
               a_res, a_carry, a_ovf, a_zero);
    end
    pop_a();
  endtask

  task automatic test_overflow();
    int lat;
    run_a(OP_ADD, 32'h7FFF_FFFF, 32'd1, lat);
    checks++;
    if ({a_res, a_carry, a_ovf, a_zero} !== {32'h8000_0000, 3'b010}) begin
      errors++;
      $display("FAIL add_ovf: got res=%h c=%b o=%b z=%b want 80000000 0 1 0",
               a_res, a_carry, a_ovf, a_zero);
    end
    pop_a();
    run_a(OP_ADDU, 32'h7FFF_FFFF, 32'd1, lat);
    checks++;
    if ({a_res, a_carry, a_ovf} !== {32'h8000_0000, 2'b00}) begin
      errors++;
      $display("FAIL addu_no_ovf: got res=%h c=%b o=%b want 80000000 0 0",
               a_res, a_carry, a_ovf);
    end
    pop_a();
    run_a(OP_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if ({a_res, a_carry, a_ovf} !== {32'hFFFF_FFFE, 2'b10}) begin
      errors++;
      $display("FAIL add_neg: got res=%h c=%b o=%b want fffffffe 1 0",
               a_res, a_carry, a_ovf);
    end
    pop_a();
  endtask

  task automatic test_sub();
    int lat;
    run_a(OP_SUB, 32'd5, 32'd5, lat);
    checks++;
    if ({a_res, a_carry, a_ovf, a_zero} !== {32'd0, 3'b101}) begin
      errors++;
      $display("FAIL sub_5_5: got res=%h c=%b o=%b z=%b want 0 1 0 1",
               a_res, a_carry, a_ovf, a_zero);
    end
    pop_a();
    run_a(OP_SUBU, 32'd0, 32'd1, lat);
    checks++;
    if ({a_res, a_carry, a_ovf, a_zero} !== {32'hFFFF_FFFF, 3'b000}) begin
      errors++;
      $display("FAIL subu_0_1: got res=%h c=%b o=%b z=%b want ffffffff 0 0 0",
               a_res, a_carry, a_ovf, a_zero);
    end
    pop_a();
    run_a(OP_SUB, 32'h8000_0000, 32'd1, lat);
    checks++;
    if ({a_res, a_carry, a_ovf, a_zero} !== {32'h7FFF_FFFF, 3'b110}) begin
      errors++;
      $display("FAIL sub_ovf: got res=%h c=%b o=%b z=%b want 7fffffff 1 1 0",
               a_res, a_carry, a_ovf, a_zero);
    end
    pop_a();
  endtask

  task automatic test_hold();
    int lat;
    run_a(OP_ADD, 32'd1, 32'd2, lat);
    a_op       = OP_ADD;
    a_d1       = 32'd50;
    a_d2       = 32'd60;
    a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({a_out_valid, a_in_ready, a_res} !== {2'b10, 32'd3}) begin
        errors++;
        $display("FAIL hold_%0d: got ov=%b ir=%b res=%h want 1 0 3",
                 i, a_out_valid, a_in_ready, a_res);
      end
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    checks++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release: got ir=%b ov=%b want 1 0",
               a_in_ready, a_out_valid);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || a_res !== 32'd110) begin
      errors++;
      $display("FAIL hold_next: got lat=%0d res=%h want 4 6e", lat, a_res);
    end
    pop_a();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a_op       = OP_ADD;
    a_d1       = 32'hFFFF_FFFF;
    a_d2       = 32'h1234_5678;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_out_valid, a_res, a_carry, a_ovf, a_zero} !== 36'd0) begin
      errors++;
      $display("FAIL rst_mid_run: got ov=%b res=%h c=%b o=%b z=%b want all 0",
               a_out_valid, a_res, a_carry, a_ovf, a_zero);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b want 1", a_in_ready);
    end
    run_a(OP_ADD, 32'd100, 32'd4, lat);
    checks++;
    if (lat !== 4 || a_res !== 32'd104) begin
      errors++;
      $display("FAIL post_rst_add: got lat=%0d res=%h want 4 68", lat, a_res);
    end
    pop_a();
  endtask

  task automatic test_single_chunk();
    int lat;
    b_op       = OP_ADDU;
    b_d1       = 16'hFFFF;
    b_d2       = 16'h0001;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL w16_latency: got %0d want 1", lat);
    end
    checks++;
    if ({b_res, b_carry, b_ovf, b_zero} !== {16'h0000, 3'b101}) begin
      errors++;
      $display("FAIL w16_addu: got res=%h c=%b o=%b z=%b want 0000 1 0 1",
               b_res, b_carry, b_ovf, b_zero);
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    a_in_valid  = 1'b0;
    a_op        = OP_ADD;
    a_d1        = '0;
    a_d2        = '0;
    a_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    b_op        = OP_ADD;
    b_d1        = '0;
    b_d2        = '0;
    b_out_ready = 1'b0;
    #2;
    test_reset();
    @(posedge clk); #1;
    test_add();
    test_overflow();
    test_sub();
    test_hold();
    test_reset_mid_run();
    test_single_chunk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
